// File: rtl/io_port_endpoint.sv
// Device-side terminator for one MMIO port pair: TX FIFO toward the peripheral,
// RX holding register back to the CPU, and the polled status word.
module io_port_endpoint #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inform_write,
    input  logic [15:0] wr_hi,
    input  logic [15:0] wr_lo,
    input  logic        inform_read,
    output logic [15:0] rd_hi,
    output logic [15:0] rd_lo,
    output logic        dev_tx_valid,
    output logic [31:0] dev_tx_data,
    input  logic        dev_tx_ready,
    input  logic        dev_rx_valid,
    input  logic [15:0] dev_rx_data,
    output logic        dev_rx_ready
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_tx_valid;
    logic          r_rx_valid;
    logic [15:0]   r_rx_data;
    logic          r_ovf;
    logic          r_prev_write;
    logic          r_prev_read;

    logic          w_wr_evt;
    logic          w_rd_evt;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_ovf_set;
    logic [CW-1:0] w_count_nxt;
    logic [7:0]    w_count8;

    assign w_wr_evt  = inform_write & ~r_prev_write;
    assign w_rd_evt  = inform_read & ~r_prev_read;
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_pop     = r_tx_valid & dev_tx_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign w_push    = w_wr_evt & (~w_full | w_pop);
    assign w_ovf_set = w_wr_evt & w_full & ~w_pop;
    assign w_count8  = 8'(r_count);

    // Next occupancy from the push/pop pair.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {wr_hi, wr_lo};
        end
    end

    // Pointers, count, valid, edge detectors and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_tx_valid   <= 1'b0;
            r_ovf        <= 1'b0;
            r_prev_write <= 1'b0;
            r_prev_read  <= 1'b0;
        end else begin
            r_prev_write <= inform_write;
            r_prev_read  <= inform_read;
            r_count      <= w_count_nxt;
            r_tx_valid   <= (w_count_nxt != '0);
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            // Overflow set wins over a coincident read clear.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_rd_evt) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // RX holding register; data persists after consumption.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= 16'h0000;
        end else if (dev_rx_valid && !r_rx_valid) begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= dev_rx_data;
        end else if (w_rd_evt) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign dev_tx_valid = r_tx_valid;
    assign dev_tx_data  = r_mem[r_rptr];
    assign dev_rx_ready = ~r_rx_valid;
    assign rd_hi        = r_rx_data;
    assign rd_lo        = {r_rx_valid, w_full, (r_count == '0), r_ovf, 4'b0000, w_count8};

endmodule

// File: doc/io_port_endpoint.md
Name: io_port_endpoint

Overview:
- Device-side terminator for one MMIO port pair of the CPU's memory-mapped IO controller.
- Receives the controller's 32-bit port writes (odd/even word pair plus write-inform strobe) and buffers them in a TX FIFO toward the peripheral.
- Captures peripheral data into a receive holding register that the CPU reads back through the port's read words.
- Produces the status word the CPU polls.

Parameters:
- FIFO_DEPTH, 4, number of 32-bit TX entries. Power of two, 2..128.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- inform_write  in  1  controller write strobe for this port; an event is its rising edge
- wr_hi  in  16  odd-address word from controller, valid with inform_write
- wr_lo  in  16  even-address word from controller, valid with inform_write
- inform_read  in  1  controller read-inform for this port; an event is its rising edge
- rd_hi  out  16  odd-address read word = RX data
- rd_lo  out  16  even-address read word = status
- dev_tx_valid  out  1  TX FIFO head valid toward peripheral
- dev_tx_data  out  32  {wr_hi, wr_lo} at FIFO head
- dev_tx_ready  in  1  peripheral accepts head
- dev_rx_valid  in  1  peripheral offers data
- dev_rx_data  in  16  peripheral data
- dev_rx_ready  out  1  endpoint can accept RX data

Behaviour:
- Clock and reset:
  - One clock (clk). Reset is synchronous, active-low (rst_n), sampled on the rising edge.
- Reset values:
  - FIFO empty, count 0, rx_valid 0, rx_data 0, overflow 0.
  - Edge-detect registers 0; dev_tx_valid 0; dev_rx_ready 1.
  - rd_hi = 16'h0000; rd_lo = 16'h2000.
- Status word (rd_lo):
  - [15] rx_valid, [14] tx_full, [13] tx_empty, [12] tx_overflow (sticky).
  - [11:8] 0; [7:0] tx_count, zero-extended.
  - Derived purely from registers, no input-to-output combinational path.
- rd_hi:
  - Equals rx_data register. Holds its last value after being consumed; it is not cleared.
- Write event (inform_write=1 and prev_write=0):
  - Push {wr_hi, wr_lo}.
  - A level held high produces exactly one push.
  - If FIFO is full and no pop occurs in the same cycle: drop the data, set tx_overflow, leave count unchanged.
- TX pop:
  - Occurs when dev_tx_valid && dev_tx_ready.
  - dev_tx_valid = (count != 0), registered.
  - dev_tx_data is the head entry and stays stable while valid && !ready.
- Simultaneous push and pop:
  - Both occur; count unchanged.
  - This applies when full as well: the push is accepted because a slot frees that cycle.
  - When empty, the push is written and valid rises next cycle, with no bypass.
- Latency and pointers:
  - Write event at edge N on an empty FIFO gives dev_tx_valid=1 after edge N, visible in cycle N+1.
  - Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- RX accept:
  - dev_rx_ready = !rx_valid, registered-state derived.
  - On dev_rx_valid && dev_rx_ready: rx_data <= dev_rx_data, rx_valid <= 1.
  - No same-cycle refill while rx_valid=1.
- Read event (inform_read=1 and prev_read=0):
  - The controller samples rd_hi/rd_lo on this same edge, so it sees pre-event values.
  - At this edge: rx_valid <= 0 and tx_overflow <= 0, i.e. consume-on-read. A read of either word consumes both.
  - If rx_valid was 0, only tx_overflow clears.
- Read event coincident with an RX handshake:
  - Impossible, since ready requires rx_valid=0. The clear simply has no effect.
- Read event coincident with an overflowing write:
  - Overflow stays set; the set wins over the clear.
- Reset mid-operation:
  - rst_n=0 at any edge discards FIFO contents and RX data, and returns all state to reset values that edge.
  - Outstanding dev_tx_valid drops the following cycle.

Test Plan:
- Reset then idle:
  - rd_lo=16'h2000, rd_hi=0, dev_tx_valid=0, dev_rx_ready=1.
- Single write, hi=16'hBEEF lo=16'h1234, dev_tx_ready=0:
  - dev_tx_valid=1 one cycle later, dev_tx_data=32'hBEEF1234, rd_lo=16'h0001.
  - Holds stable for 5 cycles; ready pulse pops it, rd_lo returns to 16'h2000.
- Five writes (values 1..5), FIFO_DEPTH=4, ready=0:
  - rd_lo=16'h5004 (full + overflow, count 4).
  - Draining yields 1,2,3,4 in order; value 5 is lost.
  - A read event clears overflow, giving rd_lo=16'h2000.
- inform_write held high 10 cycles:
  - Exactly one push, count=1.
- Full FIFO, write event and ready=1 in the same cycle:
  - Count stays 4, no overflow; new entry is delivered last.
- dev_rx offers 16'hA5A5:
  - rx_valid=1, rd_hi=16'hA5A5, dev_rx_ready=0.
  - Read event: the sample sees bit15=1; next cycle rx_valid=0, ready=1.
  - A second offer of 16'h0042 is accepted only after that.
